oqpsk_rx_demod: RTL
===================

Name: oqpsk_rx_demod

Overview:
- Baseband OQPSK demodulator that sits at the receive end of the link fed by the OQPSK raised-cosine transmitter.
- Accepts signed 13-bit I/Q sample pairs and integrates I and Q over one symbol each, with Q offset by half a symbol.
- Slices each integral to one bit and returns the recovered bit stream in transmit order through a small output FIFO with a valid/ack handshake.

Parameters:
- SPS, 8, samples per symbol (power of 2, ≥4); Q dump offset = SPS/2.
- W, 13, I/Q sample width (two's complement).
- ACC_W, W+log2(SPS), accumulator width; cannot overflow.
- FIFO_D, 4, output bit FIFO depth (power of 2).

Ports:
- CLK  in  1  single system clock, rising edge.
- RST  in  1  asynchronous, active-low reset.
- EN  in  1  demod enable; low holds the demod datapath in idle.
- SAMPLE_VALID  in  1  one-cycle strobe; I_In/Q_In are valid this cycle.
- I_In  in  W  signed in-phase sample.
- Q_In  in  W  signed quadrature sample.
- Bit_Out  out  1  recovered bit at FIFO head.
- BIT_VALID  out  1  FIFO non-empty.
- BIT_ACK  in  1  consumer accepts Bit_Out when BIT_VALID=1.
- OVF  out  1  sticky overflow flag (bit dropped).

Behaviour:
- Reset (RST=0, async): phase=0, acc_i=acc_q=0, q_armed=0, FIFO empty, Bit_Out=0, BIT_VALID=0, OVF=0. All outputs are registered.
- States:
  - IDLE (EN=0): phase, accumulators and q_armed held at 0; OVF cleared; FIFO keeps its contents and still drains via BIT_ACK.
  - RUN (EN=1): IDLE->RUN when EN=1; RUN->IDLE as soon as EN=0, mid-symbol included, and the partial symbol is discarded.
- Phase counter: 0..SPS-1, advances only on SAMPLE_VALID in RUN and wraps to 0. The first valid sample after entering RUN is phase 0.
- I path: acc_i accumulates sign-extended I_In on every valid sample.
  - On the valid sample with phase=SPS-1, total = acc_i + I_In (that sample included).
  - Push bit (total ≥ 0 ? 1 : 0), reload acc_i to 0, set q_armed=1.
- Q path: identical, but dumps on the valid sample with phase=SPS/2-1.
  - If q_armed=0, the Q bit is discarded (partial first half-symbol); acc_q still resets.
- Bit order out of the FIFO: I0, Q0, I1, Q1, … I and Q pushes never coincide.
- Latency: a bit pushed at edge N appears on Bit_Out/BIT_VALID after edge N if the FIFO was empty (BIT_VALID is high the cycle after the dump sample).
- FIFO:
  - Pop occurs when BIT_VALID & BIT_ACK at the clock edge.
  - Push and pop in the same cycle are both performed, including when full (no overflow).
  - Push while full with no pop: the new bit is dropped and OVF is set. OVF holds until reset or EN=0.
  - BIT_ACK while empty is ignored.
  - Read and write pointers wrap modulo FIFO_D.
- SAMPLE_VALID gaps of any length are allowed and change no state.
- Zero total slices to 1.
- Full-scale check: -2^(W-1)*SPS = -32768 fits ACC_W=16.

Test Plan:
1. Reset: assert RST=0 mid-stream, with the FIFO holding 2 bits -> Bit_Out=0, BIT_VALID=0, OVF=0 immediately (no clock). After release, the first bit appears only after a full SPS-sample I symbol.
2. Steady stream: EN=1, BIT_ACK=1, 16 consecutive valid samples with I=+1000, Q=-1000.
   - Sample 4: Q dump discarded.
   - Sample 8: I bit 1.
   - Sample 12: Q bit 0.
   - Sample 16: I bit 1.
   - Consumed sequence is 1,0,1; BIT_VALID rises the cycle after samples 8, 12 and 16.
3. Slicer boundaries, one I symbol each:
   - I sums to 0 -> bit 1.
   - I sums to -1 -> bit 0.
   - I=-4096 for all 8 samples -> bit 0, no wrap.
   - I=+4095 for all 8 samples -> bit 1.
4. Back-pressure: BIT_ACK=0 for 3 symbols (5 bit pushes) -> BIT_VALID=1 and FIFO full after 4 pushes; 5th push dropped, OVF=1. Raising BIT_ACK then pops exactly the first 4 bits in order, and OVF stays 1.
5. Full + simultaneous: FIFO full, BIT_ACK=1 on the cycle of an I dump -> pop and push both occur, OVF stays 0, FIFO remains full.
6. EN drop mid-symbol: deassert EN after 5 valid samples, then reassert.
   - Phase restarts at 0 and the prior partial sums have no effect on later bits.
   - First Q dump after re-enable is discarded; OVF cleared while EN=0.
   - FIFO contents are preserved and drain normally.

Source files
------------

// File: rtl/oqpsk_rx_demod.sv
// oqpsk_rx_demod
//   Baseband OQPSK receive demodulator. Integrates I over each symbol and Q
//   over each symbol shifted by half a symbol, slices each integral to one
//   bit, and queues the bits (I0, Q0, I1, Q1, ...) in a small output FIFO.
//
// Ports
//   CLK          system clock, rising edge
//   RST          asynchronous active-low reset
//   EN           demod enable; low keeps the integrators idle and clears OVF
//   SAMPLE_VALID I_In/Q_In valid this cycle
//   I_In, Q_In   signed W-bit samples
//   Bit_Out      FIFO head bit (registered)
//   BIT_VALID    FIFO non-empty (registered)
//   BIT_ACK      consumer pops the head when BIT_VALID=1
//   OVF          sticky "bit dropped because FIFO was full"
module oqpsk_rx_demod #(
  parameter int SPS    = 8,
  parameter int W      = 13,
  parameter int FIFO_D = 4
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                EN,
  input  logic                SAMPLE_VALID,
  input  logic signed [W-1:0] I_In,
  input  logic signed [W-1:0] Q_In,
  output logic                Bit_Out,
  output logic                BIT_VALID,
  input  logic                BIT_ACK,
  output logic                OVF
);

  localparam int ACC_W = W + $clog2(SPS);
  localparam int EXT_W = ACC_W - W;
  localparam int PH_W  = $clog2(SPS);
  localparam int PTR_W = $clog2(FIFO_D);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [PH_W-1:0]  PH_I_DUMP = PH_W'(SPS - 1);
  localparam logic [PH_W-1:0]  PH_Q_DUMP = PH_W'(SPS / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(FIFO_D);

  typedef logic signed [ACC_W-1:0] acc_t;

  // Demod datapath state
  logic [PH_W-1:0]   phase_q, phase_d;
  acc_t              acc_i_q, acc_i_d;
  acc_t              acc_q_q, acc_q_d;
  logic              q_armed_q, q_armed_d;

  // Output FIFO state
  logic [FIFO_D-1:0] mem_q, mem_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              bit_out_q, bit_out_d;
  logic              bit_valid_q, bit_valid_d;

  // Integrate-and-dump sums including the current sample
  acc_t tot_i, tot_q;
  logic push, push_bit, pop, full, wr_en;

  assign tot_i = acc_i_q + acc_t'({{EXT_W{I_In[W-1]}}, I_In});
  assign tot_q = acc_q_q + acc_t'({{EXT_W{Q_In[W-1]}}, Q_In});

  always_comb begin
    phase_d     = phase_q;
    acc_i_d     = acc_i_q;
    acc_q_d     = acc_q_q;
    q_armed_d   = q_armed_q;
    mem_d       = mem_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    push        = 1'b0;
    push_bit    = 1'b0;

    if (!EN) begin
      // Idle: any partial symbol is discarded, next sample restarts at phase 0
      phase_d   = '0;
      acc_i_d   = '0;
      acc_q_d   = '0;
      q_armed_d = 1'b0;
      ovf_d     = 1'b0;
    end else if (SAMPLE_VALID) begin
      phase_d = phase_q + PH_W'(1);
      acc_i_d = tot_i;
      acc_q_d = tot_q;
      // Slicer: sign bit clear (total >= 0, zero included) -> 1
      if (phase_q == PH_I_DUMP) begin
        push      = 1'b1;
        push_bit  = ~tot_i[ACC_W-1];
        acc_i_d   = '0;
        q_armed_d = 1'b1;
      end
      // Q dump before the first I dump only covers half a symbol: drop it
      if (phase_q == PH_Q_DUMP) begin
        acc_q_d = '0;
        if (q_armed_q) begin
          push     = 1'b1;
          push_bit = ~tot_q[ACC_W-1];
        end
      end
    end

    // FIFO: a pop frees the slot, so push+pop while full still succeeds
    pop   = bit_valid_q & BIT_ACK;
    full  = (cnt_q == CNT_FULL);
    wr_en = push & (~full | pop);
    if (push & full & ~pop) ovf_d = 1'b1;

    if (wr_en) begin
      mem_d[wr_ptr_q] = push_bit;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);

    case ({wr_en, pop})
      2'b10:   cnt_d = cnt_q + CNT_W'(1);
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: cnt_d = cnt_q;
    endcase

    // Registered head: look ahead to the post-edge FIFO state
    bit_valid_d = (cnt_d != '0);
    bit_out_d   = bit_valid_d & mem_d[rd_ptr_d];
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      phase_q     <= '0;
      acc_i_q     <= '0;
      acc_q_q     <= '0;
      q_armed_q   <= 1'b0;
      mem_q       <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      phase_q     <= phase_d;
      acc_i_q     <= acc_i_d;
      acc_q_q     <= acc_q_d;
      q_armed_q   <= q_armed_d;
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      bit_out_q   <= bit_out_d;
      bit_valid_q <= bit_valid_d;
    end
  end

  assign Bit_Out   = bit_out_q;
  assign BIT_VALID = bit_valid_q;
  assign OVF       = ovf_q;

endmodule
